// File: rtl/core_pkg.sv
// Shared core types.
//  InsnIDNum    : number of in-flight vector instruction IDs (power of two, >= 2)
//  insn_id_t    : instruction ID
//  retire_req_t : payload of the retire channel towards the scalar core
package core_pkg;

  localparam int unsigned InsnIDNum = 8;

  typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;

  typedef struct packed {
    insn_id_t id;
    logic     illegal;
  } retire_req_t;

endpackage

// File: rtl/insn_retire_scheduler.sv
// In-order retire scheduler for vector instructions.
// IDs are handed out in program order from a circular window [head, tail).
// The commit controller reports done/illegal out of order. The oldest ID is
// retired to the scalar core only after it is done.
//  clk_i, rst_i          clock, async active-high reset
//  alloc_req_i/gnt_o/id_o  ID allocation towards the decoder
//  done_i/done_id_i/done_illegal_i  completion reports from the commit controller
//  retire_valid_o/ready_i/id_o/illegal_o  in-order retire channel to the scalar core
//  inflight_cnt_o, idle_o  occupancy; idle_o is used for vector fences
//  err_o                 sticky protocol error (bad or duplicate done report)
module insn_retire_scheduler
  import core_pkg::*;
#(
  parameter int unsigned NrIds   = InsnIDNum,
  parameter int unsigned IdWidth = $clog2(NrIds)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alloc_req_i,
  output logic               alloc_gnt_o,
  output logic [IdWidth-1:0] alloc_id_o,
  input  logic               done_i,
  input  logic [IdWidth-1:0] done_id_i,
  input  logic               done_illegal_i,
  output logic               retire_valid_o,
  input  logic               retire_ready_i,
  output logic [IdWidth-1:0] retire_id_o,
  output logic               retire_illegal_o,
  output logic [IdWidth:0]   inflight_cnt_o,
  output logic               idle_o,
  output logic               err_o
);

  localparam logic [IdWidth:0]   CntOne  = (IdWidth+1)'(1);
  localparam logic [IdWidth:0]   CntFull = (IdWidth+1)'(NrIds);
  localparam logic [IdWidth-1:0] IdOne   = IdWidth'(1);

  logic [IdWidth-1:0] head_q, head_d;
  logic [IdWidth-1:0] tail_q, tail_d;
  logic [IdWidth:0]   cnt_q, cnt_d;
  logic [NrIds-1:0]   done_q, done_d;
  logic [NrIds-1:0]   illegal_q, illegal_d;
  logic               err_q, err_d;

  logic        alloc_fire;
  logic        retire_fire;
  logic        done_accept;
  retire_req_t retire_req;

  // An ID is in flight when its distance from head (mod NrIds) is below cnt.
  // When full every ID is in flight; when empty none is.
  function automatic logic in_flight(input logic [IdWidth-1:0] id,
                                     input logic [IdWidth-1:0] head,
                                     input logic [IdWidth:0]   cnt);
    logic [IdWidth-1:0] off;
    off = id - head;
    return {1'b0, off} < cnt;
  endfunction

  // Grant uses registered occupancy only: a retire in the same cycle does not
  // free a slot until the next cycle.
  assign alloc_gnt_o = alloc_req_i && (cnt_q != CntFull);
  assign alloc_fire  = alloc_gnt_o;
  assign alloc_id_o  = tail_q;

  assign retire_req.id      = head_q;
  assign retire_req.illegal = illegal_q[head_q];

  assign retire_valid_o   = (cnt_q != '0) && done_q[head_q];
  assign retire_id_o      = retire_req.id;
  assign retire_illegal_o = retire_req.illegal;
  assign retire_fire      = retire_valid_o && retire_ready_i;

  // A done on the head that is retiring now is necessarily a duplicate, and a
  // done on the slot being allocated now is outside the window, so the three
  // updates below never touch the same entry.
  assign done_accept = done_i && in_flight(done_id_i, head_q, cnt_q) && !done_q[done_id_i];

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    illegal_d = illegal_q;
    err_d     = err_q;

    if (alloc_fire) begin
      done_d[tail_q]    = 1'b0;
      illegal_d[tail_q] = 1'b0;
      tail_d            = tail_q + IdOne;
    end

    if (done_i) begin
      if (done_accept) begin
        done_d[done_id_i]    = 1'b1;
        illegal_d[done_id_i] = done_illegal_i;
      end else begin
        err_d = 1'b1;
      end
    end

    if (retire_fire) begin
      done_d[head_q] = 1'b0;
      head_d         = head_q + IdOne;
    end

    case ({alloc_fire, retire_fire})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      done_q    <= '0;
      illegal_q <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  assign inflight_cnt_o = cnt_q;
  assign idle_o         = (cnt_q == '0);
  assign err_o          = err_q;

  a_no_gnt_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(alloc_gnt_o && (cnt_q == CntFull)));

  a_retire_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (retire_valid_o && !retire_ready_i) |=>
      (retire_valid_o && $stable(retire_id_o) && $stable(retire_illegal_o)));

endmodule

// File: tb/tb_insn_retire_scheduler.sv
module tb_insn_retire_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       alloc_req_i = 1'b0;
  logic       alloc_gnt_o;
  logic [2:0] alloc_id_o;
  logic       done_i = 1'b0;
  logic [2:0] done_id_i = '0;
  logic       done_illegal_i = 1'b0;
  logic       retire_valid_o;
  logic       retire_ready_i = 1'b0;
  logic [2:0] retire_id_o;
  logic       retire_illegal_o;
  logic [3:0] inflight_cnt_o;
  logic       idle_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  insn_retire_scheduler dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alloc_req_i     (alloc_req_i),
    .alloc_gnt_o     (alloc_gnt_o),
    .alloc_id_o      (alloc_id_o),
    .done_i          (done_i),
    .done_id_i       (done_id_i),
    .done_illegal_i  (done_illegal_i),
    .retire_valid_o  (retire_valid_o),
    .retire_ready_i  (retire_ready_i),
    .retire_id_o     (retire_id_o),
    .retire_illegal_o(retire_illegal_o),
    .inflight_cnt_o  (inflight_cnt_o),
    .idle_o          (idle_o),
    .err_o           (err_o)
  );

  typedef struct {
    logic       req;
    logic       done;
    logic [2:0] did;
    logic       dill;
    logic       rdy;
    logic       gnt;
    logic [2:0] aid;
    logic       rv;
    logic [2:0] rid;
    logic       rill;
    logic [3:0] cnt;
    logic       idle;
    logic       err;
  } vec_t;

  function automatic vec_t mk(logic req, logic done, logic [2:0] did, logic dill, logic rdy,
                              logic gnt, logic [2:0] aid, logic rv, logic [2:0] rid,
                              logic rill, logic [3:0] cnt, logic idle, logic err);
    vec_t v;
    v.req = req; v.done = done; v.did = did; v.dill = dill; v.rdy = rdy;
    v.gnt = gnt; v.aid = aid; v.rv = rv; v.rid = rid; v.rill = rill;
    v.cnt = cnt; v.idle = idle; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".gnt"},  int'(alloc_gnt_o),      int'(v.gnt));
    chk({tag, ".aid"},  int'(alloc_id_o),       int'(v.aid));
    chk({tag, ".rv"},   int'(retire_valid_o),   int'(v.rv));
    chk({tag, ".rid"},  int'(retire_id_o),      int'(v.rid));
    chk({tag, ".rill"}, int'(retire_illegal_o), int'(v.rill));
    chk({tag, ".cnt"},  int'(inflight_cnt_o),   int'(v.cnt));
    chk({tag, ".idle"}, int'(idle_o),           int'(v.idle));
    chk({tag, ".err"},  int'(err_o),            int'(v.err));
  endtask

  // Drive a vector after the falling edge, compare the pre-edge outputs,
  // the vector then takes effect on the next rising edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk_i);
    alloc_req_i    = v.req;
    done_i         = v.done;
    done_id_i      = v.did;
    done_illegal_i = v.dill;
    retire_ready_i = v.rdy;
    #1;
    chk_outs(tag, v);
  endtask

  task automatic idle_inputs();
    alloc_req_i = 1'b0; done_i = 1'b0; done_id_i = '0;
    done_illegal_i = 1'b0; retire_ready_i = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    #1;
    chk_outs(tag, mk(0,0,0,0,0, 0,0,0,0,0,0,1,0));
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  vec_t vecs[19];

  initial begin
    // req done did dill rdy | gnt aid rv rid rill cnt idle err
    vecs[0]  = mk(1,0,0,0,0, 1,0,0,0,0,0,1,0);
    vecs[1]  = mk(1,0,0,0,0, 1,1,0,0,0,1,0,0);
    vecs[2]  = mk(1,0,0,0,0, 1,2,0,0,0,2,0,0);
    vecs[3]  = mk(0,1,2,0,0, 0,3,0,0,0,3,0,0);
    vecs[4]  = mk(0,1,0,0,1, 0,3,0,0,0,3,0,0);
    vecs[5]  = mk(0,1,1,0,1, 0,3,1,0,0,3,0,0);
    vecs[6]  = mk(0,0,0,0,1, 0,3,1,1,0,2,0,0);
    vecs[7]  = mk(0,0,0,0,1, 0,3,1,2,0,1,0,0);
    vecs[8]  = mk(0,0,0,0,1, 0,3,0,3,0,0,1,0);
    vecs[9]  = mk(1,0,0,0,0, 1,3,0,3,0,0,1,0);
    vecs[10] = mk(1,0,0,0,0, 1,4,0,3,0,1,0,0);
    vecs[11] = mk(1,0,0,0,0, 1,5,0,3,0,2,0,0);
    vecs[12] = mk(0,1,4,1,0, 0,6,0,3,0,3,0,0);
    vecs[13] = mk(0,1,4,0,1, 0,6,0,3,0,3,0,0);
    vecs[14] = mk(0,0,0,0,1, 0,6,0,3,0,3,0,1);
    vecs[15] = mk(0,1,3,0,0, 0,6,0,3,0,3,0,1);
    vecs[16] = mk(0,0,0,0,1, 0,6,1,3,0,3,0,1);
    vecs[17] = mk(0,0,0,0,1, 0,6,1,4,1,2,0,1);
    vecs[18] = mk(0,0,0,0,0, 0,6,0,5,0,1,0,1);

    // Power-on reset, with alloc_req_i high to see gnt follow the request.
    #2;
    alloc_req_i = 1'b1;
    #1;
    chk_outs("por", mk(1,0,0,0,0, 1,0,0,0,0,0,1,0));
    alloc_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 19; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Done for an ID outside [head, tail).
    do_reset("rstA1");
    apply("a1_0", mk(1,0,0,0,0, 1,0,0,0,0,0,1,0));
    apply("a1_1", mk(1,0,0,0,0, 1,1,0,0,0,1,0,0));
    apply("a1_2", mk(1,0,0,0,0, 1,2,0,0,0,2,0,0));
    apply("a1_3", mk(0,1,5,0,0, 0,3,0,0,0,3,0,0));
    apply("a1_4", mk(0,0,0,0,1, 0,3,0,0,0,3,0,1));

    // Done for the ID being allocated in the same cycle.
    do_reset("rstA2");
    apply("a2_0", mk(1,0,0,0,0, 1,0,0,0,0,0,1,0));
    apply("a2_1", mk(1,0,0,0,0, 1,1,0,0,0,1,0,0));
    apply("a2_2", mk(1,0,0,0,0, 1,2,0,0,0,2,0,0));
    apply("a2_3", mk(1,1,3,0,0, 1,3,0,0,0,3,0,0));
    apply("a2_4", mk(0,0,0,0,1, 0,4,0,0,0,4,0,1));

    // Fill, full stall, no same-cycle bypass, wrap to ID0.
    do_reset("rstB");
    for (int i = 0; i < 8; i++)
      apply($sformatf("b_fill%0d", i),
            mk(1,0,0,0,0, 1,3'(i),0,0,0,4'(i),(i == 0),0));
    apply("b_full",   mk(1,1,0,0,0, 0,0,0,0,0,8,0,0));
    apply("b_retire", mk(1,0,0,0,1, 0,0,1,0,0,8,0,0));
    apply("b_wrap",   mk(1,0,0,0,0, 1,0,0,1,0,7,0,0));
    apply("b_after",  mk(0,0,0,0,0, 0,1,0,1,0,8,0,0));

    // Retire back-pressure with an illegal instruction.
    do_reset("rstC");
    apply("c_alloc", mk(1,0,0,0,0, 1,0,0,0,0,0,1,0));
    apply("c_done",  mk(0,1,0,1,0, 0,1,0,0,0,1,0,0));
    for (int i = 0; i < 3; i++)
      apply($sformatf("c_hold%0d", i), mk(0,0,0,0,0, 0,1,1,0,1,1,0,0));
    apply("c_ret",   mk(0,0,0,0,1, 0,1,1,0,1,1,0,0));
    apply("c_empty", mk(0,0,0,0,0, 0,1,0,1,0,0,1,0));

    // Reset mid-operation: 4 in flight, 2 done.
    do_reset("rstD");
    for (int i = 0; i < 4; i++)
      apply($sformatf("d_alloc%0d", i),
            mk(1,0,0,0,0, 1,3'(i),0,0,0,4'(i),(i == 0),0));
    apply("d_done0", mk(0,1,0,0,0, 0,4,0,0,0,4,0,0));
    apply("d_done1", mk(0,1,1,0,0, 0,4,1,0,0,4,0,0));
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk_outs("d_pre", mk(0,0,0,0,0, 0,4,1,0,0,4,0,0));
    #2;
    rst_i = 1'b1;
    alloc_req_i = 1'b1;
    #1;
    chk_outs("d_rst", mk(1,0,0,0,0, 1,0,0,0,0,0,1,0));
    @(negedge clk_i);
    rst_i = 1'b0;
    alloc_req_i = 1'b0;
    apply("d_new0", mk(1,0,0,0,0, 1,0,0,0,0,0,1,0));
    apply("d_new1", mk(0,0,0,0,1, 0,1,0,0,0,1,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
